reg_read_port: RTL

//  - Read side of the general/pointer/index register file: two-operand fetch unit with valid/ready on both sides.
//  - Decodes 3-bit 8086 reg fields plus the w bit into 8/16-bit operands taken from the AX..DI register outputs.
//  - Buffers responses in a small FIFO so that decode can run ahead of execute.
//  - Sits between instruction decode (requester) and the ALU/execute stage (consumer).

---
 rtl/reg_read_port.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/reg_read_port.sv
// ============================================================================
// reg_read_port
// ----------------------------------------------------------------------------
// Read side of the general/pointer/index register file. Decode hands in two
// 8086 reg fields plus the w bit; the block returns two 8/16-bit operands
// (and the request's opaque tag) through a small response FIFO, so decode can
// run ahead of the execute stage.
//
// Operand values are captured when the request is accepted. Queued entries
// never track later register-file changes.
//
// Configuration macro: REG_READ_BYPASS_EN
//   defined   : operands see the post-write value of each register for the
//               accept cycle (en_write / data_in / select_data_h_reg used).
//   undefined : operands are the pre-write register values; the bypass
//               inputs remain on the port list and are ignored.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_valid / req_ready        request handshake
//   req_w                        0 = 8-bit operands, 1 = 16-bit operands
//   req_reg_a / req_reg_b        3-bit reg fields for operands A and B
//   req_sext                     8-bit only: sign-extend (1) or zero-extend (0)
//   req_tag                      opaque tag returned with the response
//   AX..BP                       current register-file outputs
//   en_write, data_in,
//   select_data_h_reg            register-file write port (bypass only)
//   rsp_valid / rsp_ready        response handshake
//   rsp_a, rsp_b, rsp_tag        FIFO head (hold last values when empty)
//   occupancy                    number of stored responses
// ============================================================================
module reg_read_port #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_w,
    input  logic [2:0]                 req_reg_a,
    input  logic [2:0]                 req_reg_b,
    input  logic                       req_sext,
    input  logic [TAG_W-1:0]           req_tag,
    input  logic [15:0]                AX,
    input  logic [15:0]                BX,
    input  logic [15:0]                CX,
    input  logic [15:0]                DX,
    input  logic [15:0]                SI,
    input  logic [15:0]                DI,
    input  logic [15:0]                SP,
    input  logic [15:0]                BP,
    input  logic [15:0]                en_write,
    input  logic [15:0]                data_in,
    input  logic                       select_data_h_reg,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [15:0]                rsp_a,
    output logic [15:0]                rsp_b,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ------------------------------------------------------------------
    // Register values seen by the operand decode
    // ------------------------------------------------------------------
    logic [15:0] ax_v, bx_v, cx_v, dx_v, si_v, di_v, sp_v, bp_v;

`ifdef REG_READ_BYPASS_EN
    // Post-write value of a byte-addressable register. Only one write
    // applies per register: full word beats low byte beats high byte.
    function automatic logic [15:0] wr_word(
        input logic [15:0] cur,
        input logic        full_en,
        input logic        lo_en,
        input logic        hi_en,
        input logic [15:0] din,
        input logic        sel_h
    );
        logic [15:0] res;
        res = cur;
        if (full_en) begin
            res = din;
        end else if (lo_en) begin
            res[7:0] = din[7:0];
        end else if (hi_en) begin
            res[15:8] = sel_h ? din[15:8] : din[7:0];
        end
        return res;
    endfunction

    assign ax_v = wr_word(AX, en_write[0], en_write[12], en_write[8],  data_in, select_data_h_reg);
    assign bx_v = wr_word(BX, en_write[1], en_write[13], en_write[9],  data_in, select_data_h_reg);
    assign cx_v = wr_word(CX, en_write[2], en_write[14], en_write[10], data_in, select_data_h_reg);
    assign dx_v = wr_word(DX, en_write[3], en_write[15], en_write[11], data_in, select_data_h_reg);
    assign si_v = en_write[4] ? data_in : SI;
    assign di_v = en_write[5] ? data_in : DI;
    assign sp_v = en_write[6] ? data_in : SP;
    assign bp_v = en_write[7] ? data_in : BP;
`else
    assign ax_v = AX;
    assign bx_v = BX;
    assign cx_v = CX;
    assign dx_v = DX;
    assign si_v = SI;
    assign di_v = DI;
    assign sp_v = SP;
    assign bp_v = BP;

    // Write-port inputs have no function in this build.
    logic unused_bypass;
    assign unused_bypass = ^{en_write, data_in, select_data_h_reg};
`endif

    // Indexed in 16-bit reg-field order. Entries 0..3 are also the
    // AX/CX/DX/BX sources for the 8-bit fields (bit 2 picks the high byte).
    logic [15:0] reg_val [8];
    assign reg_val[0] = ax_v;
    assign reg_val[1] = cx_v;
    assign reg_val[2] = dx_v;
    assign reg_val[3] = bx_v;
    assign reg_val[4] = sp_v;
    assign reg_val[5] = bp_v;
    assign reg_val[6] = si_v;
    assign reg_val[7] = di_v;

    // ------------------------------------------------------------------
    // Operand decode (A = 0, B = 1)
    // ------------------------------------------------------------------
    logic [2:0]  op_sel [2];
    logic [15:0] op_val [2];

    assign op_sel[0] = req_reg_a;
    assign op_sel[1] = req_reg_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            logic [15:0] byte_src;
            logic [7:0]  sel_byte;

            assign byte_src    = reg_val[{1'b0, op_sel[gi][1:0]}];
            assign sel_byte    = op_sel[gi][2] ? byte_src[15:8] : byte_src[7:0];
            assign op_val[gi]  = req_w ? reg_val[op_sel[gi]]
                                       : {{8{req_sext & sel_byte[7]}}, sel_byte};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [15:0]      mem_a_q   [DEPTH];
    logic [15:0]      mem_b_q   [DEPTH];
    logic [TAG_W-1:0] mem_tag_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q,  count_d;
    logic [15:0]      rsp_a_q,  rsp_a_d;
    logic [15:0]      rsp_b_q,  rsp_b_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // No pass-through when full: a same-cycle pop does not open req_ready.
    assign req_ready = (count_q < OCC_W'(DEPTH));
    assign rsp_valid = (count_q != '0);
    assign push      = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rsp_a_d   = rsp_a_q;
        rsp_b_d   = rsp_b_q;
        rsp_tag_d = rsp_tag_q;

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + OCC_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - OCC_W'(1);
        end

        // The output registers always mirror the next head. If the next head
        // is the slot being written this cycle, take the incoming operands
        // directly since the storage array has not been updated yet. When the
        // FIFO drains, the outputs keep their last values.
        if (count_d != '0) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                rsp_a_d   = op_val[0];
                rsp_b_d   = op_val[1];
                rsp_tag_d = req_tag;
            end else begin
                rsp_a_d   = mem_a_q[rd_ptr_d];
                rsp_b_d   = mem_b_q[rd_ptr_d];
                rsp_tag_d = mem_tag_q[rd_ptr_d];
            end
        end
    end

    // Payload storage needs no reset: nothing reads an entry before it is
    // written, because rsp_* come from their own reset registers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q]   <= op_val[0];
            mem_b_q[wr_ptr_q]   <= op_val[1];
            mem_tag_q[wr_ptr_q] <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rsp_a_q   <= '0;
            rsp_b_q   <= '0;
            rsp_tag_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rsp_a_q   <= rsp_a_d;
            rsp_b_q   <= rsp_b_d;
            rsp_tag_q <= rsp_tag_d;
        end
    end

    assign rsp_a     = rsp_a_q;
    assign rsp_b     = rsp_b_q;
    assign rsp_tag   = rsp_tag_q;
    assign occupancy = count_q;

endmodule
